// File: rtl/ram_arb_pkg.sv
// Shared encodings for the two-requester block RAM arbiter.
package ram_arb_pkg;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_0    = 2'd1;
  localparam logic [1:0] OWN_1    = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } lock_state_e;

endpackage

// File: rtl/ram_arbiter_pick.sv
// Combinational two-way winner select: a held lock beats the tie-break,
// which is either fixed (requester 0) or the one that did not win last.
module arb2_pick (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  input  logic       fixed_prio,
  input  logic [1:0] lock_hold,
  output logic       gnt0,
  output logic       gnt1
);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      if (lock_hold[0])      gnt0 = 1'b1;
      else if (lock_hold[1]) gnt1 = 1'b1;
      else if (fixed_prio)   gnt0 = 1'b1;
      else if (last)         gnt0 = 1'b1;
      else                   gnt1 = 1'b1;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Monitor (0) / CPU (1) arbiter for the shared block RAM: one access per
// cycle, round-robin or fixed priority, burst lock with a starvation guard.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int addr_width = 12,
  parameter int data_width = 8,
  parameter int burst_max  = 16,
  parameter int fixed_prio = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [addr_width-1:0] addr0,
  input  logic [addr_width-1:0] addr1,
  input  logic [data_width-1:0] wdata0,
  input  logic [data_width-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [data_width-1:0] rdata0,
  output logic [data_width-1:0] rdata1,
  output logic [addr_width-1:0] r_waddr,
  output logic [addr_width-1:0] r_raddr,
  output logic [data_width-1:0] r_din,
  output logic                  r_write_en,
  input  logic [data_width-1:0] r_dout,
  output logic [1:0]            owner
);

  localparam logic [7:0] BURST_LIM = 8'(burst_max);

  lock_state_e           r_state;
  logic [7:0]            r_cnt;
  logic                  r_last;
  logic [1:0]            r_force;
  logic                  r_rvalid0;
  logic                  r_rvalid1;
  logic [1:0]            r_owner;
  logic [addr_width-1:0] r_addr_q;
  logic [data_width-1:0] r_din_q;

  logic                  w_pick0;
  logic                  w_pick1;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_any;
  logic [1:0]            w_hold;
  logic [addr_width-1:0] w_addr;
  logic [data_width-1:0] w_wdata;
  logic                  w_lock_win;
  logic                  w_other;
  logic                  w_cont;
  logic [7:0]            w_cnt_inc;
  logic                  w_expire;

  // r_force carries the starvation hand-off: after an expired burst the
  // waiting side wins the next tie even under fixed priority.
  assign w_hold[0] = ((r_state == OWN0) && req0 && lock0) || r_force[0];
  assign w_hold[1] = ((r_state == OWN1) && req1 && lock1) || r_force[1];

  arb2_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last       (r_last),
    .fixed_prio (fixed_prio != 0),
    .lock_hold  (w_hold),
    .gnt0       (w_pick0),
    .gnt1       (w_pick1)
  );

  assign w_gnt0 = w_pick0 & rst;
  assign w_gnt1 = w_pick1 & rst;
  assign w_any  = w_gnt0 | w_gnt1;

  assign w_addr  = w_gnt1 ? addr1  : addr0;
  assign w_wdata = w_gnt1 ? wdata1 : wdata0;

  assign gnt0       = w_gnt0;
  assign gnt1       = w_gnt1;
  assign r_write_en = (w_gnt0 & we0) | (w_gnt1 & we1);
  assign r_waddr    = w_any ? w_addr  : r_addr_q;
  assign r_raddr    = w_any ? w_addr  : r_addr_q;
  assign r_din      = w_any ? w_wdata : r_din_q;

  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata0  = r_dout;
  assign rdata1  = r_dout;
  assign owner   = r_owner;

  // Burst accounting only counts cycles where the other side was kept waiting.
  assign w_lock_win = (w_gnt0 & lock0) | (w_gnt1 & lock1);
  assign w_other    = w_gnt0 ? req1 : req0;
  assign w_cont     = ((r_state == OWN0) && w_gnt0) || ((r_state == OWN1) && w_gnt1);
  assign w_cnt_inc  = (w_cont ? r_cnt : 8'd0) + {7'd0, w_other};
  assign w_expire   = (w_cnt_inc >= BURST_LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_last    <= 1'b1;
      r_force   <= 2'b00;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_owner   <= OWN_NONE;
    end else begin
      r_rvalid0 <= w_gnt0 & ~we0;
      r_rvalid1 <= w_gnt1 & ~we1;
      r_owner   <= w_gnt0 ? OWN_0 : (w_gnt1 ? OWN_1 : OWN_NONE);
      if (w_any) begin
        r_last  <= w_gnt1;
        r_force <= 2'b00;
      end
      if (w_lock_win) begin
        if (w_expire) begin
          r_state <= IDLE;
          r_cnt   <= 8'd0;
          r_force <= w_gnt0 ? 2'b10 : 2'b01;
        end else begin
          r_state <= w_gnt0 ? OWN0 : OWN1;
          r_cnt   <= w_cnt_inc;
        end
      end else begin
        r_state <= IDLE;
        r_cnt   <= 8'd0;
      end
    end
  end

  // Idle-cycle copy of the RAM inputs so the address bus does not toggle.
  always_ff @(posedge clk) begin
    if (w_any) begin
      r_addr_q <= w_addr;
      r_din_q  <= w_wdata;
    end
  end

endmodule
